mem_access_ctrl: RTL

Request front-end that sits directly upstream of the single-port synchronous memory array and is the only master driving it. After reset, and on a clear request, it sweeps every address with a fill value. It then serves one read or write at a time over a valid/ready request channel and a valid/ready response channel. It absorbs the array's one-cycle registered read latency and holds read data until the consumer takes it.

---
 rtl/mem_access_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Front-end that owns a single-port synchronous memory array: fills it on reset/clear,
// then serves one read or write at a time and holds read data until it is consumed.
//
// state   | meaning
// --------+-----------------------------------------------------------
// INIT    | sweeping every address with INIT_VALUE, one word per cycle
// IDLE    | ready for a request or a clear
// RD_WAIT | read address issued, array output arrives this cycle
// RESP    | read data presented, waiting for the consumer to take it
module mem_access_ctrl #(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    ADDR_WIDTH = 4,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_req,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  init_done,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   input  logic [DATA_WIDTH-1:0] mem_dout
);

   localparam int                    DEPTH     = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [1:0] {INIT, IDLE, RD_WAIT, RESP} state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   sweep_cnt;
   logic                    accept;

   // A clear in IDLE masks ready so a coincident request is never half-accepted.
   assign req_ready = (state == IDLE) && !clr_req;
   assign accept    = req_valid && req_ready;
   assign init_done = (state != INIT);

   always_comb begin
      mem_we   = 1'b0;
      mem_addr = req_addr;
      mem_din  = req_wdata;
      case (state)
         INIT: begin
            mem_we   = 1'b1;
            mem_addr = sweep_cnt;
            mem_din  = INIT_VALUE;
         end
         IDLE:    mem_we = accept && req_we;
         default: mem_we = 1'b0;
      endcase
      if (rst) mem_we = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= INIT;
         sweep_cnt <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         case (state)
            INIT: begin
               if (sweep_cnt == LAST_ADDR) begin
                  sweep_cnt <= '0;
                  state     <= IDLE;
               end else begin
                  sweep_cnt <= sweep_cnt + 1'b1;
               end
            end
            IDLE: begin
               if (clr_req)
                  state <= INIT;
               else if (accept && !req_we)
                  state <= RD_WAIT;
            end
            RD_WAIT: begin
               rsp_rdata <= mem_dout;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule
